// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
//
// Shares one iterative divider between two requesters. One request is in
// flight at a time. Requesters are chosen round-robin, and each request runs
// through a four-state FSM:
//   IDLE  -> grant a requester and latch its operands
//   ISSUE -> pulse START_DIV with the latched operands
//   WAIT  -> hold the operands until DONE_DIV, then capture RES_DIV
//   RESP  -> strobe RESP_VALID for the granted requester
// A requester can kill its own outstanding request with FLUSH. The divider
// still finishes, the FSM still passes through RESP, but no response strobe
// is produced.
//
// Configuration:
//   DIV_RESULT_CACHE_EN  When defined, a one-entry result cache remembers the
//                        last {op1, op2, cmd, result}. A grant whose operands
//                        match a valid entry goes straight to RESP with the
//                        cached result, and START_DIV is not pulsed.
//                        When undefined, there is no cache storage and every
//                        grant goes through ISSUE and WAIT.
//
// Ports:
//   clk                    single clock, rising-edge
//   reset_n                synchronous active-low reset
//   REQ_VALID_0/1          requester i presents a request
//   REQ_OP1_0/1 [31:0]     dividend of requester i
//   REQ_OP2_0/1 [31:0]     divisor of requester i
//   REQ_CMD_0/1 [1:0]      00 remu, 01 div, 10 divu, 11 rem
//   REQ_READY_0/1          request of requester i accepted this cycle
//   FLUSH_0/1              requester i kills its outstanding request
//   RESP_VALID_0/1         one-cycle result strobe to requester i
//   RESP_DATA [31:0]       shared result bus, zero unless a strobe is high
//   OP1_SE/OP2_SE [31:0]   operands to the divider
//   CMD_RD [1:0]           command to the divider
//   START_DIV              one-cycle divider start pulse
//   DONE_DIV               divider result valid on RES_DIV
//   RES_DIV [31:0]         divider result
// -----------------------------------------------------------------------------
module div_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        REQ_VALID_0,
  input  logic        REQ_VALID_1,
  input  logic [31:0] REQ_OP1_0,
  input  logic [31:0] REQ_OP1_1,
  input  logic [31:0] REQ_OP2_0,
  input  logic [31:0] REQ_OP2_1,
  input  logic [1:0]  REQ_CMD_0,
  input  logic [1:0]  REQ_CMD_1,
  output logic        REQ_READY_0,
  output logic        REQ_READY_1,
  input  logic        FLUSH_0,
  input  logic        FLUSH_1,
  output logic        RESP_VALID_0,
  output logic        RESP_VALID_1,
  output logic [31:0] RESP_DATA,
  output logic [31:0] OP1_SE,
  output logic [31:0] OP2_SE,
  output logic [1:0]  CMD_RD,
  output logic        START_DIV,
  input  logic        DONE_DIV,
  input  logic [31:0] RES_DIV
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        gnt_q, gnt_d;
  logic        kill_q, kill_d;
  logic [31:0] result_q, result_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [1:0]  cmd_q, cmd_d;

  logic        elig_0, elig_1;
  logic        grant_any;
  logic        grant_id;
  logic [31:0] sel_op1, sel_op2;
  logic [1:0]  sel_cmd;
  logic        flush_g;
  logic        cache_hit;
  logic [31:0] cache_res;

  // A requester that is flushing in the same cycle is not eligible for a grant.
  assign elig_0    = REQ_VALID_0 & ~FLUSH_0;
  assign elig_1    = REQ_VALID_1 & ~FLUSH_1;
  assign grant_any = elig_0 | elig_1;

  // The pointer only matters on a tie. A sole eligible requester always wins.
  always_comb begin
    grant_id = 1'b0;
    if (elig_0 && elig_1) begin
      grant_id = ptr_q;
    end else begin
      grant_id = elig_1;
    end
  end

  assign sel_op1 = grant_id ? REQ_OP1_1 : REQ_OP1_0;
  assign sel_op2 = grant_id ? REQ_OP2_1 : REQ_OP2_0;
  assign sel_cmd = grant_id ? REQ_CMD_1 : REQ_CMD_0;

  // Only the requester that owns the in-flight request can kill it.
  assign flush_g = gnt_q ? FLUSH_1 : FLUSH_0;

`ifdef DIV_RESULT_CACHE_EN
  logic        cache_valid_q;
  logic [31:0] cache_op1_q;
  logic [31:0] cache_op2_q;
  logic [1:0]  cache_cmd_q;
  logic [31:0] cache_res_q;

  // The entry is refreshed on every completion in WAIT, killed requests
  // included. The divider did compute a correct result for those operands.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cache_valid_q <= 1'b0;
      cache_op1_q   <= '0;
      cache_op2_q   <= '0;
      cache_cmd_q   <= '0;
      cache_res_q   <= '0;
    end else if (state_q == S_WAIT && DONE_DIV) begin
      cache_valid_q <= 1'b1;
      cache_op1_q   <= op1_q;
      cache_op2_q   <= op2_q;
      cache_cmd_q   <= cmd_q;
      cache_res_q   <= RES_DIV;
    end
  end

  assign cache_hit = cache_valid_q && (cache_op1_q == sel_op1) &&
                     (cache_op2_q == sel_op2) && (cache_cmd_q == sel_cmd);
  assign cache_res = cache_res_q;
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b0;
      gnt_q    <= 1'b0;
      kill_q   <= 1'b0;
      result_q <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      cmd_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      kill_q   <= kill_d;
      result_q <= result_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      cmd_q    <= cmd_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    kill_d   = kill_q;
    result_d = result_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    cmd_d    = cmd_q;

    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          gnt_d  = grant_id;
          // The pointer moves to the requester that was not just served.
          ptr_d  = ~grant_id;
          kill_d = 1'b0;
          op1_d  = sel_op1;
          op2_d  = sel_op2;
          cmd_d  = sel_cmd;
          if (cache_hit) begin
            result_d = cache_res;
            state_d  = S_RESP;
          end else begin
            state_d  = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        if (flush_g) begin
          kill_d = 1'b1;
        end
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (flush_g) begin
          kill_d = 1'b1;
        end
        // A kill, whether earlier or in this same cycle, discards the result.
        if (DONE_DIV) begin
          result_d = (kill_q || flush_g) ? 32'd0 : RES_DIV;
          state_d  = S_RESP;
        end
      end

      S_RESP: begin
        kill_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are forced to zero while reset_n is low. This keeps REQ_READY and
  // the divider interface quiet in the reset cycle itself, not just after it.
  always_comb begin
    REQ_READY_0  = 1'b0;
    REQ_READY_1  = 1'b0;
    RESP_VALID_0 = 1'b0;
    RESP_VALID_1 = 1'b0;
    RESP_DATA    = '0;
    OP1_SE       = '0;
    OP2_SE       = '0;
    CMD_RD       = '0;
    START_DIV    = 1'b0;

    if (reset_n) begin
      case (state_q)
        S_IDLE: begin
          REQ_READY_0 = grant_any & ~grant_id;
          REQ_READY_1 = grant_any &  grant_id;
        end

        S_ISSUE: begin
          START_DIV = 1'b1;
          OP1_SE    = op1_q;
          OP2_SE    = op2_q;
          CMD_RD    = cmd_q;
        end

        S_WAIT: begin
          OP1_SE = op1_q;
          OP2_SE = op2_q;
          CMD_RD = cmd_q;
        end

        S_RESP: begin
          if (!kill_q) begin
            RESP_VALID_0 = ~gnt_q;
            RESP_VALID_1 =  gnt_q;
            RESP_DATA    = result_q;
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// -----------------------------------------------------------------------------
// tb_div_arbiter
//
// Directed bench for div_arbiter. Inputs change right after the falling edge,
// and outputs are sampled 1 ns later, well away from the rising edge. The bench
// plays the divider itself: it drives DONE_DIV and RES_DIV with hand-computed
// quotients and remainders.
// -----------------------------------------------------------------------------
module tb_div_arbiter;

  logic        clk;
  logic        reset_n;
  logic        REQ_VALID_0, REQ_VALID_1;
  logic [31:0] REQ_OP1_0, REQ_OP1_1, REQ_OP2_0, REQ_OP2_1;
  logic [1:0]  REQ_CMD_0, REQ_CMD_1;
  logic        REQ_READY_0, REQ_READY_1;
  logic        FLUSH_0, FLUSH_1;
  logic        RESP_VALID_0, RESP_VALID_1;
  logic [31:0] RESP_DATA;
  logic [31:0] OP1_SE, OP2_SE;
  logic [1:0]  CMD_RD;
  logic        START_DIV;
  logic        DONE_DIV;
  logic [31:0] RES_DIV;

  int n_cmp = 0;
  int n_err = 0;

  div_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .REQ_VALID_0  (REQ_VALID_0),
    .REQ_VALID_1  (REQ_VALID_1),
    .REQ_OP1_0    (REQ_OP1_0),
    .REQ_OP1_1    (REQ_OP1_1),
    .REQ_OP2_0    (REQ_OP2_0),
    .REQ_OP2_1    (REQ_OP2_1),
    .REQ_CMD_0    (REQ_CMD_0),
    .REQ_CMD_1    (REQ_CMD_1),
    .REQ_READY_0  (REQ_READY_0),
    .REQ_READY_1  (REQ_READY_1),
    .FLUSH_0      (FLUSH_0),
    .FLUSH_1      (FLUSH_1),
    .RESP_VALID_0 (RESP_VALID_0),
    .RESP_VALID_1 (RESP_VALID_1),
    .RESP_DATA    (RESP_DATA),
    .OP1_SE       (OP1_SE),
    .OP2_SE       (OP2_SE),
    .CMD_RD       (CMD_RD),
    .START_DIV    (START_DIV),
    .DONE_DIV     (DONE_DIV),
    .RES_DIV      (RES_DIV)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net: the sequence is fully directed, so this only fires on a hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    REQ_VALID_0 = 1'b1; REQ_OP1_0 = 32'd40; REQ_OP2_0 = 32'd5; REQ_CMD_0 = 2'b10;
    REQ_VALID_1 = 1'b1; REQ_OP1_1 = 32'd81; REQ_OP2_1 = 32'd9; REQ_CMD_1 = 2'b10;
    DONE_DIV = 1'b1; RES_DIV = 32'hDEAD_BEEF;
    cyc(); cyc(); #1;
    n_cmp++; if (REQ_READY_0 !== 1'b0) begin n_err++; $display("[TB] FAIL rst_ready0: got %b want 0", REQ_READY_0); end
    n_cmp++; if (REQ_READY_1 !== 1'b0) begin n_err++; $display("[TB] FAIL rst_ready1: got %b want 0", REQ_READY_1); end
    n_cmp++; if (START_DIV !== 1'b0) begin n_err++; $display("[TB] FAIL rst_start: got %b want 0", START_DIV); end
    n_cmp++; if (RESP_VALID_0 !== 1'b0) begin n_err++; $display("[TB] FAIL rst_rv0: got %b want 0", RESP_VALID_0); end
    n_cmp++; if (RESP_VALID_1 !== 1'b0) begin n_err++; $display("[TB] FAIL rst_rv1: got %b want 0", RESP_VALID_1); end
    n_cmp++; if (RESP_DATA !== 32'd0) begin n_err++; $display("[TB] FAIL rst_data: got %h want 0", RESP_DATA); end
    n_cmp++; if (OP1_SE !== 32'd0) begin n_err++; $display("[TB] FAIL rst_op1: got %h want 0", OP1_SE); end
    n_cmp++; if (OP2_SE !== 32'd0) begin n_err++; $display("[TB] FAIL rst_op2: got %h want 0", OP2_SE); end
    n_cmp++; if (CMD_RD !== 2'b00) begin n_err++; $display("[TB] FAIL rst_cmd: got %b want 00", CMD_RD); end
  endtask

  // Both requesters are valid when reset is released. Requester 0 goes first,
  // then requester 1, then requester 0 again on the next tie.
  task automatic test_round_robin();
    cyc(); reset_n = 1'b1; DONE_DIV = 1'b0; #1;
    n_cmp++; if (REQ_READY_0 !== 1'b1) begin n_err++; $display("[TB] FAIL rr_g0_ready0: got %b want 1", REQ_READY_0); end
    n_cmp++; if (REQ_READY_1 !== 1'b0) begin n_err++; $display("[TB] FAIL rr_g0_ready1: got %b want 0", REQ_READY_1); end
    cyc(); REQ_VALID_0 = 1'b0; #1;
    n_cmp++; if (START_DIV !== 1'b1) begin n_err++; $display("[TB] FAIL rr_g0_start: got %b want 1", START_DIV); end
    n_cmp++; if (OP1_SE !== 32'd40) begin n_err++; $display("[TB] FAIL rr_g0_op1: got %0d want 40", OP1_SE); end
    n_cmp++; if (OP2_SE !== 32'd5) begin n_err++; $display("[TB] FAIL rr_g0_op2: got %0d want 5", OP2_SE); end
    n_cmp++; if (CMD_RD !== 2'b10) begin n_err++; $display("[TB] FAIL rr_g0_cmd: got %b want 10", CMD_RD); end
    n_cmp++; if (REQ_READY_1 !== 1'b0) begin n_err++; $display("[TB] FAIL rr_issue_ready1: got %b want 0", REQ_READY_1); end
    cyc(); DONE_DIV = 1'b1; RES_DIV = 32'd8; #1;
    n_cmp++; if (START_DIV !== 1'b0) begin n_err++; $display("[TB] FAIL rr_wait_start: got %b want 0", START_DIV); end
    n_cmp++; if (OP1_SE !== 32'd40) begin n_err++; $display("[TB] FAIL rr_wait_op1: got %0d want 40", OP1_SE); end
    cyc(); DONE_DIV = 1'b0; #1;
    n_cmp++; if (RESP_VALID_0 !== 1'b1) begin n_err++; $display("[TB] FAIL rr_g0_rv0: got %b want 1", RESP_VALID_0); end
    n_cmp++; if (RESP_DATA !== 32'd8) begin n_err++; $display("[TB] FAIL rr_g0_data: got %0d want 8", RESP_DATA); end
    n_cmp++; if (REQ_READY_1 !== 1'b0) begin n_err++; $display("[TB] FAIL rr_resp_ready1: got %b want 0", REQ_READY_1); end
    cyc(); #1;
    n_cmp++; if (REQ_READY_1 !== 1'b1) begin n_err++; $display("[TB] FAIL rr_g1_ready1: got %b want 1", REQ_READY_1); end
    n_cmp++; if (RESP_DATA !== 32'd0) begin n_err++; $display("[TB] FAIL rr_idle_data: got %0d want 0", RESP_DATA); end
    cyc(); REQ_VALID_1 = 1'b0; #1;
    n_cmp++; if (OP1_SE !== 32'd81) begin n_err++; $display("[TB] FAIL rr_g1_op1: got %0d want 81", OP1_SE); end
    cyc(); DONE_DIV = 1'b1; RES_DIV = 32'd9;
    cyc(); DONE_DIV = 1'b0; #1;
    n_cmp++; if (RESP_VALID_1 !== 1'b1) begin n_err++; $display("[TB] FAIL rr_g1_rv1: got %b want 1", RESP_VALID_1); end
    n_cmp++; if (RESP_VALID_0 !== 1'b0) begin n_err++; $display("[TB] FAIL rr_g1_rv0: got %b want 0", RESP_VALID_0); end
    n_cmp++; if (RESP_DATA !== 32'd9) begin n_err++; $display("[TB] FAIL rr_g1_data: got %0d want 9", RESP_DATA); end
    cyc();
    REQ_VALID_0 = 1'b1; REQ_OP1_0 = 32'd12; REQ_OP2_0 = 32'd4;
    REQ_VALID_1 = 1'b1; REQ_OP1_1 = 32'd33; REQ_OP2_1 = 32'd3; #1;
    n_cmp++; if (REQ_READY_0 !== 1'b1) begin n_err++; $display("[TB] FAIL rr_g2_ready0: got %b want 1", REQ_READY_0); end
    n_cmp++; if (REQ_READY_1 !== 1'b0) begin n_err++; $display("[TB] FAIL rr_g2_ready1: got %b want 0", REQ_READY_1); end
    cyc(); REQ_VALID_0 = 1'b0; REQ_VALID_1 = 1'b0; #1;
    n_cmp++; if (OP1_SE !== 32'd12) begin n_err++; $display("[TB] FAIL rr_g2_op1: got %0d want 12", OP1_SE); end
    cyc(); DONE_DIV = 1'b1; RES_DIV = 32'd3;
    cyc(); DONE_DIV = 1'b0; #1;
    n_cmp++; if (RESP_DATA !== 32'd3) begin n_err++; $display("[TB] FAIL rr_g2_data: got %0d want 3", RESP_DATA); end
  endtask

  // 100 divu 7 = 14, with one extra WAIT cycle before the divider finishes.
  task automatic test_basic();
    cyc(); REQ_VALID_0 = 1'b1; REQ_OP1_0 = 32'd100; REQ_OP2_0 = 32'd7; REQ_CMD_0 = 2'b10; #1;
    n_cmp++; if (REQ_READY_0 !== 1'b1) begin n_err++; $display("[TB] FAIL basic_ready0: got %b want 1", REQ_READY_0); end
    cyc(); REQ_VALID_0 = 1'b0; #1;
    n_cmp++; if (START_DIV !== 1'b1) begin n_err++; $display("[TB] FAIL basic_start: got %b want 1", START_DIV); end
    n_cmp++; if (OP2_SE !== 32'd7) begin n_err++; $display("[TB] FAIL basic_op2: got %0d want 7", OP2_SE); end
    cyc(); #1;
    n_cmp++; if (START_DIV !== 1'b0) begin n_err++; $display("[TB] FAIL basic_start_once: got %b want 0", START_DIV); end
    n_cmp++; if (OP1_SE !== 32'd100) begin n_err++; $display("[TB] FAIL basic_hold_op1: got %0d want 100", OP1_SE); end
    cyc(); DONE_DIV = 1'b1; RES_DIV = 32'd14; #1;
    n_cmp++; if (RESP_VALID_0 !== 1'b0) begin n_err++; $display("[TB] FAIL basic_early_rv0: got %b want 0", RESP_VALID_0); end
    cyc(); DONE_DIV = 1'b0; #1;
    n_cmp++; if (RESP_VALID_0 !== 1'b1) begin n_err++; $display("[TB] FAIL basic_rv0: got %b want 1", RESP_VALID_0); end
    n_cmp++; if (RESP_DATA !== 32'd14) begin n_err++; $display("[TB] FAIL basic_data: got %0d want 14", RESP_DATA); end
    cyc(); #1;
    n_cmp++; if (RESP_VALID_0 !== 1'b0) begin n_err++; $display("[TB] FAIL basic_rv0_once: got %b want 0", RESP_VALID_0); end
    n_cmp++; if (OP1_SE !== 32'd0) begin n_err++; $display("[TB] FAIL basic_idle_op1: got %0d want 0", OP1_SE); end
    n_cmp++; if (CMD_RD !== 2'b00) begin n_err++; $display("[TB] FAIL basic_idle_cmd: got %b want 00", CMD_RD); end
  endtask

  // Requester 1 flushes during WAIT. The response is suppressed, and the
  // next request is served normally.
  task automatic test_flush();
    REQ_VALID_1 = 1'b1; REQ_OP1_1 = 32'd55; REQ_OP2_1 = 32'd11; REQ_CMD_1 = 2'b10; #1;
    n_cmp++; if (REQ_READY_1 !== 1'b1) begin n_err++; $display("[TB] FAIL flush_ready1: got %b want 1", REQ_READY_1); end
    cyc(); REQ_VALID_1 = 1'b0;
    cyc(); FLUSH_1 = 1'b1;
    cyc(); FLUSH_1 = 1'b0; DONE_DIV = 1'b1; RES_DIV = 32'd5;
    cyc(); DONE_DIV = 1'b0; #1;
    n_cmp++; if (RESP_VALID_1 !== 1'b0) begin n_err++; $display("[TB] FAIL flush_rv1: got %b want 0", RESP_VALID_1); end
    n_cmp++; if (RESP_DATA !== 32'd0) begin n_err++; $display("[TB] FAIL flush_data: got %0d want 0", RESP_DATA); end
    cyc(); REQ_VALID_0 = 1'b1; REQ_OP1_0 = 32'd60; REQ_OP2_0 = 32'd4; REQ_CMD_0 = 2'b10; #1;
    n_cmp++; if (REQ_READY_0 !== 1'b1) begin n_err++; $display("[TB] FAIL flush_next_ready0: got %b want 1", REQ_READY_0); end
    cyc(); REQ_VALID_0 = 1'b0;
    cyc(); DONE_DIV = 1'b1; RES_DIV = 32'd15;
    cyc(); DONE_DIV = 1'b0; #1;
    n_cmp++; if (RESP_VALID_0 !== 1'b1) begin n_err++; $display("[TB] FAIL flush_next_rv0: got %b want 1", RESP_VALID_0); end
    n_cmp++; if (RESP_DATA !== 32'd15) begin n_err++; $display("[TB] FAIL flush_next_data: got %0d want 15", RESP_DATA); end
  endtask

  // A FLUSH in IDLE blocks the grant, a DONE_DIV outside WAIT is ignored, and
  // a FLUSH in the same cycle as DONE_DIV kills the response.
  task automatic test_flush_corners();
    cyc(); REQ_VALID_0 = 1'b1; REQ_OP1_0 = 32'd70; REQ_OP2_0 = 32'd3; REQ_CMD_0 = 2'b00; FLUSH_0 = 1'b1; #1;
    n_cmp++; if (REQ_READY_0 !== 1'b0) begin n_err++; $display("[TB] FAIL corner_blocked_ready0: got %b want 0", REQ_READY_0); end
    cyc(); FLUSH_0 = 1'b0; DONE_DIV = 1'b1; RES_DIV = 32'h77; #1;
    n_cmp++; if (REQ_READY_0 !== 1'b1) begin n_err++; $display("[TB] FAIL corner_ready0: got %b want 1", REQ_READY_0); end
    cyc(); REQ_VALID_0 = 1'b0; RES_DIV = 32'h55; #1;
    n_cmp++; if (START_DIV !== 1'b1) begin n_err++; $display("[TB] FAIL corner_start: got %b want 1", START_DIV); end
    cyc(); DONE_DIV = 1'b0; #1;
    n_cmp++; if (RESP_VALID_0 !== 1'b0) begin n_err++; $display("[TB] FAIL corner_issue_done_rv0: got %b want 0", RESP_VALID_0); end
    n_cmp++; if (OP1_SE !== 32'd70) begin n_err++; $display("[TB] FAIL corner_wait_op1: got %0d want 70", OP1_SE); end
    cyc(); FLUSH_0 = 1'b1; DONE_DIV = 1'b1; RES_DIV = 32'h99;
    cyc(); FLUSH_0 = 1'b0; DONE_DIV = 1'b0; #1;
    n_cmp++; if (RESP_VALID_0 !== 1'b0) begin n_err++; $display("[TB] FAIL corner_kill_rv0: got %b want 0", RESP_VALID_0); end
    n_cmp++; if (RESP_DATA !== 32'd0) begin n_err++; $display("[TB] FAIL corner_kill_data: got %h want 0", RESP_DATA); end
  endtask

  // Reset during WAIT abandons the request, clears the pointer, and a later
  // stray DONE_DIV produces nothing.
  task automatic test_reset_mid();
    cyc(); REQ_VALID_0 = 1'b1; REQ_OP1_0 = 32'd90; REQ_OP2_0 = 32'd6; REQ_CMD_0 = 2'b10; #1;
    n_cmp++; if (REQ_READY_0 !== 1'b1) begin n_err++; $display("[TB] FAIL rmid_ready0: got %b want 1", REQ_READY_0); end
    cyc(); REQ_VALID_0 = 1'b0;
    cyc(); reset_n = 1'b0;
    cyc(); #1;
    n_cmp++; if (OP1_SE !== 32'd0) begin n_err++; $display("[TB] FAIL rmid_op1: got %0d want 0", OP1_SE); end
    n_cmp++; if (CMD_RD !== 2'b00) begin n_err++; $display("[TB] FAIL rmid_cmd: got %b want 00", CMD_RD); end
    n_cmp++; if (START_DIV !== 1'b0) begin n_err++; $display("[TB] FAIL rmid_start: got %b want 0", START_DIV); end
    cyc(); reset_n = 1'b1; DONE_DIV = 1'b1; RES_DIV = 32'h33;
    cyc(); DONE_DIV = 1'b0;
    REQ_VALID_0 = 1'b1; REQ_OP1_0 = 32'd200; REQ_OP2_0 = 32'd10; REQ_CMD_0 = 2'b10;
    REQ_VALID_1 = 1'b1; REQ_OP1_1 = 32'd7;   REQ_OP2_1 = 32'd7;  REQ_CMD_1 = 2'b10; #1;
    n_cmp++; if (RESP_VALID_0 !== 1'b0) begin n_err++; $display("[TB] FAIL rmid_stray_rv0: got %b want 0", RESP_VALID_0); end
    n_cmp++; if (REQ_READY_0 !== 1'b1) begin n_err++; $display("[TB] FAIL rmid_ptr_ready0: got %b want 1", REQ_READY_0); end
    n_cmp++; if (REQ_READY_1 !== 1'b0) begin n_err++; $display("[TB] FAIL rmid_ptr_ready1: got %b want 0", REQ_READY_1); end
    cyc(); REQ_VALID_0 = 1'b0; REQ_VALID_1 = 1'b0;
    cyc(); DONE_DIV = 1'b1; RES_DIV = 32'd20;
    cyc(); DONE_DIV = 1'b0; #1;
    n_cmp++; if (RESP_DATA !== 32'd20) begin n_err++; $display("[TB] FAIL rmid_data: got %0d want 20", RESP_DATA); end
  endtask

  // -20 div 3 = -6. The second identical request hits the cache when it is
  // built in. Changing the command (rem, giving -2) must go to the divider.
  task automatic test_cache();
    cyc(); REQ_VALID_0 = 1'b1; REQ_OP1_0 = 32'hFFFF_FFEC; REQ_OP2_0 = 32'd3; REQ_CMD_0 = 2'b01; #1;
    n_cmp++; if (REQ_READY_0 !== 1'b1) begin n_err++; $display("[TB] FAIL cache_first_ready0: got %b want 1", REQ_READY_0); end
    cyc(); REQ_VALID_0 = 1'b0; #1;
    n_cmp++; if (START_DIV !== 1'b1) begin n_err++; $display("[TB] FAIL cache_first_start: got %b want 1", START_DIV); end
    n_cmp++; if (OP1_SE !== 32'hFFFF_FFEC) begin n_err++; $display("[TB] FAIL cache_first_op1: got %h want ffffffec", OP1_SE); end
    cyc(); DONE_DIV = 1'b1; RES_DIV = 32'hFFFF_FFFA;
    cyc(); DONE_DIV = 1'b0; #1;
    n_cmp++; if (RESP_DATA !== 32'hFFFF_FFFA) begin n_err++; $display("[TB] FAIL cache_first_data: got %h want fffffffa", RESP_DATA); end
    cyc(); REQ_VALID_0 = 1'b1; #1;
    n_cmp++; if (REQ_READY_0 !== 1'b1) begin n_err++; $display("[TB] FAIL cache_second_ready0: got %b want 1", REQ_READY_0); end
    cyc(); REQ_VALID_0 = 1'b0; #1;
`ifdef DIV_RESULT_CACHE_EN
    n_cmp++; if (START_DIV !== 1'b0) begin n_err++; $display("[TB] FAIL cache_hit_start: got %b want 0", START_DIV); end
    n_cmp++; if (RESP_VALID_0 !== 1'b1) begin n_err++; $display("[TB] FAIL cache_hit_rv0: got %b want 1", RESP_VALID_0); end
    n_cmp++; if (RESP_DATA !== 32'hFFFF_FFFA) begin n_err++; $display("[TB] FAIL cache_hit_data: got %h want fffffffa", RESP_DATA); end
`else
    n_cmp++; if (START_DIV !== 1'b1) begin n_err++; $display("[TB] FAIL nocache_start: got %b want 1", START_DIV); end
    n_cmp++; if (RESP_VALID_0 !== 1'b0) begin n_err++; $display("[TB] FAIL nocache_rv0: got %b want 0", RESP_VALID_0); end
    cyc(); DONE_DIV = 1'b1; RES_DIV = 32'hFFFF_FFFA;
    cyc(); DONE_DIV = 1'b0; #1;
    n_cmp++; if (RESP_DATA !== 32'hFFFF_FFFA) begin n_err++; $display("[TB] FAIL nocache_data: got %h want fffffffa", RESP_DATA); end
`endif
    cyc(); REQ_VALID_0 = 1'b1; REQ_CMD_0 = 2'b11; #1;
    n_cmp++; if (REQ_READY_0 !== 1'b1) begin n_err++; $display("[TB] FAIL cache_rem_ready0: got %b want 1", REQ_READY_0); end
    cyc(); REQ_VALID_0 = 1'b0; #1;
    n_cmp++; if (START_DIV !== 1'b1) begin n_err++; $display("[TB] FAIL cache_rem_start: got %b want 1", START_DIV); end
    n_cmp++; if (CMD_RD !== 2'b11) begin n_err++; $display("[TB] FAIL cache_rem_cmd: got %b want 11", CMD_RD); end
    cyc(); DONE_DIV = 1'b1; RES_DIV = 32'hFFFF_FFFE;
    cyc(); DONE_DIV = 1'b0; #1;
    n_cmp++; if (RESP_VALID_0 !== 1'b1) begin n_err++; $display("[TB] FAIL cache_rem_rv0: got %b want 1", RESP_VALID_0); end
    n_cmp++; if (RESP_DATA !== 32'hFFFF_FFFE) begin n_err++; $display("[TB] FAIL cache_rem_data: got %h want fffffffe", RESP_DATA); end
  endtask

  initial begin
    reset_n = 1'b0;
    REQ_VALID_0 = 1'b0; REQ_VALID_1 = 1'b0;
    REQ_OP1_0 = '0; REQ_OP1_1 = '0; REQ_OP2_0 = '0; REQ_OP2_1 = '0;
    REQ_CMD_0 = '0; REQ_CMD_1 = '0;
    FLUSH_0 = 1'b0; FLUSH_1 = 1'b0;
    DONE_DIV = 1'b0; RES_DIV = '0;

    $display("[TB] starting div_arbiter directed tests");
    test_reset();
    test_round_robin();
    test_basic();
    test_flush();
    test_flush_corners();
    test_reset_mid();
    test_cache();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
